// File: rtl/multiport_sp_ram_if.sv
// Request/grant/rvalid bus shared by all masters of multiport_sp_ram.
// Per-port fields are packed side by side; port p occupies slice p.
interface multiport_sp_ram_if #(
    parameter int unsigned N_PORTS    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [N_PORTS-1:0]              port_req_i;
    logic [N_PORTS-1:0]              port_gnt_o;
    logic [N_PORTS-1:0]              port_rvalid_o;
    logic [N_PORTS-1:0]              port_we_i;
    logic [N_PORTS*ADDR_WIDTH-1:0]   port_addr_i;
    logic [N_PORTS*DATA_WIDTH/8-1:0] port_be_i;
    logic [N_PORTS*DATA_WIDTH-1:0]   port_wdata_i;
    logic [N_PORTS*DATA_WIDTH-1:0]   port_rdata_o;
    logic [N_PORTS-1:0]              port_err_o;

    modport master (
        output port_req_i, port_we_i, port_addr_i, port_be_i, port_wdata_i,
        input  port_gnt_o, port_rvalid_o, port_rdata_o, port_err_o
    );

    modport slave (
        input  port_req_i, port_we_i, port_addr_i, port_be_i, port_wdata_i,
        output port_gnt_o, port_rvalid_o, port_rdata_o, port_err_o
    );
endinterface

// File: rtl/multiport_sp_ram.sv
// N-port round-robin front end onto one single-port RAM with byte enables and range errors.
// Optional flag/result monitor registers enabled by defining MULTIPORT_SP_RAM_MONITOR_EN.
module multiport_sp_ram #(
    parameter int unsigned N_PORTS     = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] FLAG_ADDR   = 32'h0000_0FF0,
    parameter logic [31:0] RESULT_ADDR = 32'h0000_0FF4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    multiport_sp_ram_if.slave     bus,
    output logic [DATA_WIDTH-1:0] mem_flag_o,
    output logic [DATA_WIDTH-1:0] mem_result_o
);
    localparam int unsigned BYTES  = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(BYTES);
    localparam int unsigned PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      gnt_idx;
    logic [PTR_W-1:0]      cand;
    logic                  gnt_any;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BYTES-1:0]      sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [MEM_AW-1:0]     mem_idx;
    logic                  in_range;

    logic [N_PORTS-1:0]    rvalid_q;
    logic [N_PORTS-1:0]    err_q;
    logic [DATA_WIDTH-1:0] rdata_q [N_PORTS];

    // Scan from the round-robin pointer; the first requester wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            cand = PTR_W'((32'(rr_ptr) + i) % N_PORTS);
            if (!gnt_any && bus.port_req_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (rst_i) gnt_any = 1'b0;
    end

    always_comb begin
        bus.port_gnt_o = '0;
        if (gnt_any) bus.port_gnt_o[gnt_idx] = 1'b1;
    end

    always_comb begin
        sel_we    = bus.port_we_i[gnt_idx];
        sel_addr  = bus.port_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        sel_be    = bus.port_be_i[gnt_idx*BYTES +: BYTES];
        sel_wdata = bus.port_wdata_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        word_idx  = sel_addr >> OFF_W;
        in_range  = word_idx < ADDR_WIDTH'(DEPTH_WORDS);
        mem_idx   = word_idx[MEM_AW-1:0];
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (gnt_any && sel_we && in_range) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (sel_be[b]) mem[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rr_ptr   <= '0;
            for (int unsigned p = 0; p < N_PORTS; p++) rdata_q[p] <= '0;
        end else begin
            rvalid_q <= '0;
            if (gnt_any) begin
                rvalid_q[gnt_idx] <= 1'b1;
                err_q[gnt_idx]    <= !in_range;
                rdata_q[gnt_idx]  <= (!sel_we && in_range) ? mem[mem_idx] : '0;
                rr_ptr            <= (32'(gnt_idx) == N_PORTS - 1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // A response registered just before reset must not surface during the reset cycle.
    assign bus.port_rvalid_o = rvalid_q & {N_PORTS{~rst_i}};
    assign bus.port_err_o    = err_q;

    always_comb begin
        bus.port_rdata_o = '0;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            bus.port_rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rdata_q[p];
        end
    end

`ifdef MULTIPORT_SP_RAM_MONITOR_EN
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

    logic [DATA_WIDTH-1:0] flag_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  flag_hit;
    logic                  result_hit;

    assign flag_hit   = (sel_addr & ALIGN_MASK) == ADDR_WIDTH'(FLAG_ADDR);
    assign result_hit = (sel_addr & ALIGN_MASK) == ADDR_WIDTH'(RESULT_ADDR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flag_q   <= '0;
            result_q <= '0;
        end else if (gnt_any && sel_we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (sel_be[b] && flag_hit)   flag_q[b*8 +: 8]   <= sel_wdata[b*8 +: 8];
                if (sel_be[b] && result_hit) result_q[b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
        end
    end

    assign mem_flag_o   = flag_q;
    assign mem_result_o = result_q;
`else
    assign mem_flag_o   = '0;
    assign mem_result_o = '0;
`endif
endmodule

// File: tb/tb_multiport_sp_ram.sv
// Scoreboard bench for multiport_sp_ram: reference memory/arbiter model, expected responses queued at grant.
module tb_multiport_sp_ram;
    localparam int unsigned N     = 2;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] mem_flag;
    logic [DW-1:0] mem_result;

    always #5 clk = ~clk;

    multiport_sp_ram_if #(.N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    multiport_sp_ram #(
        .N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEPTH),
        .FLAG_ADDR(32'h0000_0FF0), .RESULT_ADDR(32'h0000_0FF4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .mem_flag_o(mem_flag), .mem_result_o(mem_result)
    );

    typedef struct {
        int unsigned port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [int unsigned];
    logic [31:0] tb_flag = '0;
    logic [31:0] tb_result = '0;
    int unsigned tb_ptr = 0;
    logic [31:0] last_rdata [N];
    logic        last_err [N];
    logic        sb_en = 1'b0;

    // Reference model of one granted access: updates state and queues the expected response.
    task automatic model_access(input int unsigned p, input logic we, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wdata);
        exp_t        e;
        int unsigned idx;
        logic [31:0] cur;
        idx     = addr >> 2;
        e.port  = p;
        e.err   = (idx >= DEPTH);
        e.rdata = '0;
        if (!e.err) begin
            if (we) begin
                cur = model_mem.exists(idx) ? model_mem[idx] : 'x;
                for (int unsigned b = 0; b < 4; b++) if (be[b]) cur[b*8 +: 8] = wdata[b*8 +: 8];
                model_mem[idx] = cur;
            end else begin
                e.rdata = model_mem[idx];
            end
        end
`ifdef MULTIPORT_SP_RAM_MONITOR_EN
        if (we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b] && (addr & ~32'h3) == 32'h0FF0) tb_flag[b*8 +: 8] = wdata[b*8 +: 8];
                if (be[b] && (addr & ~32'h3) == 32'h0FF4) tb_result[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
`endif
        sb_q.push_back(e);
        tb_ptr = (p + 1) % N;
    endtask

    task automatic set_port(input int unsigned p, input logic req, input logic we,
                            input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
        bus.port_req_i[p]             = req;
        bus.port_we_i[p]              = we;
        bus.port_addr_i[p*AW +: AW]   = addr;
        bus.port_be_i[p*4 +: 4]       = be;
        bus.port_wdata_i[p*DW +: DW]  = wdata;
    endtask

    task automatic model_reset();
        tb_ptr    = 0;
        tb_flag   = '0;
        tb_result = '0;
        for (int unsigned p = 0; p < N; p++) begin
            last_rdata[p] = '0;
            last_err[p]   = 1'b0;
        end
    endtask

    // Drives one isolated access; returns gnt seen in the request cycle and rvalid one cycle later.
    task automatic single_access(input int unsigned p, input logic we, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata,
                                 output logic [N-1:0] gnt_seen, output logic [N-1:0] rv_seen);
        @(posedge clk); #1;
        set_port(p, 1'b1, we, addr, be, wdata);
        model_access(p, we, addr, be, wdata);
        @(negedge clk);
        gnt_seen = bus.port_gnt_o;
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        rv_seen = bus.port_rvalid_o;
    endtask

    // Scoreboard: every rvalid must match the oldest expectation; idle ports must hold.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            for (int unsigned p = 0; p < N; p++) begin
                if (bus.port_rvalid_o[p]) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rvalid port %0d: rvalid=1 required 0", p);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        if (e.port !== p || bus.port_rdata_o[p*DW +: DW] !== e.rdata ||
                            bus.port_err_o[p] !== e.err) begin
                            errors++;
                            $display("FAIL response: port=%0d rdata=%h err=%b, required port=%0d rdata=%h err=%b",
                                     p, bus.port_rdata_o[p*DW +: DW], bus.port_err_o[p],
                                     e.port, e.rdata, e.err);
                        end
                        last_rdata[p] = e.rdata;
                        last_err[p]   = e.err;
                    end
                end else begin
                    checks++;
                    if (bus.port_rdata_o[p*DW +: DW] !== last_rdata[p] || bus.port_err_o[p] !== last_err[p]) begin
                        errors++;
                        $display("FAIL hold port %0d: rdata=%h err=%b, required rdata=%h err=%b",
                                 p, bus.port_rdata_o[p*DW +: DW], bus.port_err_o[p], last_rdata[p], last_err[p]);
                    end
                end
            end
        end
    end

    task automatic drain(input string name);
        int unsigned n;
        n = 0;
        while (sb_q.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d responses outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_port(0, 1'b1, 1'b0, '0, '0, '0);
        set_port(1, 1'b1, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.port_gnt_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_gnt: gnt=%b required 00", bus.port_gnt_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
        model_reset();
        @(negedge clk);
        checks++;
        if (bus.port_rvalid_o !== '0 || bus.port_err_o !== '0 || bus.port_rdata_o !== '0 ||
            mem_flag !== '0 || mem_result !== '0) begin
            errors++;
            $display("FAIL reset_state: rvalid=%b err=%b rdata=%h flag=%h result=%h required all zero",
                     bus.port_rvalid_o, bus.port_err_o, bus.port_rdata_o, mem_flag, mem_result);
        end
        sb_en = 1'b1;
    endtask

    task automatic test_write_read();
        logic [N-1:0] g, rv;
        single_access(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, g, rv);
        checks++;
        if (g !== 2'b01 || rv !== 2'b01) begin
            errors++;
            $display("FAIL write_timing: gnt=%b rvalid=%b required 01 01", g, rv);
        end
        single_access(0, 1'b0, 32'h10, 4'hF, '0, g, rv);
        checks++;
        if (g !== 2'b01 || rv !== 2'b01) begin
            errors++;
            $display("FAIL read_timing: gnt=%b rvalid=%b required 01 01", g, rv);
        end
        @(negedge clk);
        checks++;
        if (bus.port_rvalid_o !== 2'b00) begin
            errors++;
            $display("FAIL rvalid_single_cycle: rvalid=%b required 00", bus.port_rvalid_o);
        end
        drain("write_read");
    endtask

    task automatic test_byte_enables();
        logic [N-1:0] g, rv;
        single_access(1, 1'b1, 32'h20, 4'hF, 32'h1122_3344, g, rv);
        single_access(1, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, g, rv);
        single_access(1, 1'b0, 32'h20, 4'hF, '0, g, rv);
        single_access(0, 1'b1, 32'h20, 4'b0000, 32'hFFFF_FFFF, g, rv);
        checks++;
        if (g !== 2'b01 || rv !== 2'b01) begin
            errors++;
            $display("FAIL be0_write: gnt=%b rvalid=%b required 01 01", g, rv);
        end
        single_access(1, 1'b0, 32'h23, 4'hF, '0, g, rv);
        drain("byte_enables");
    endtask

    task automatic test_back_to_back();
        int unsigned w, prev;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        set_port(0, 1'b1, 1'b0, 32'h10, 4'hF, '0);
        set_port(1, 1'b1, 1'b0, 32'h20, 4'hF, '0);
        prev = 0;
        for (int unsigned k = 0; k < 4; k++) begin
            w = tb_ptr;
            model_access(w, 1'b0, (w == 0) ? 32'h10 : 32'h20, 4'hF, '0);
            @(negedge clk);
            checks++;
            if (bus.port_gnt_o !== N'(1 << w) || w != (k % 2)) begin
                errors++;
                $display("FAIL rr_gnt cycle %0d: gnt=%b required %b", k, bus.port_gnt_o, N'(1 << (k % 2)));
            end
            if (k > 0) begin
                checks++;
                if (bus.port_rvalid_o !== N'(1 << prev)) begin
                    errors++;
                    $display("FAIL rr_rvalid cycle %0d: rvalid=%b required %b", k, bus.port_rvalid_o, N'(1 << prev));
                end
            end
            prev = w;
            @(posedge clk); #1;
        end
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (bus.port_rvalid_o !== N'(1 << prev)) begin
            errors++;
            $display("FAIL rr_rvalid last: rvalid=%b required %b", bus.port_rvalid_o, N'(1 << prev));
        end
        drain("back_to_back");
    endtask

    task automatic test_out_of_range();
        logic [N-1:0] g, rv;
        single_access(0, 1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, g, rv);
        single_access(0, 1'b0, 32'h1000, 4'hF, '0, g, rv);
        single_access(1, 1'b1, 32'h1000, 4'hF, 32'h1234_5678, g, rv);
        single_access(1, 1'b0, 32'h0, 4'hF, '0, g, rv);
        single_access(0, 1'b1, 32'hFFC, 4'hF, 32'h5A5A_0FFC, g, rv);
        single_access(0, 1'b0, 32'hFFC, 4'hF, '0, g, rv);
        single_access(1, 1'b0, 32'hFFFF_FFF0, 4'hF, '0, g, rv);
        drain("out_of_range");
    endtask

    task automatic test_reset_squash();
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 32'h10, 4'hF, '0);
        @(negedge clk);
        checks++;
        if (bus.port_gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL squash_gnt: gnt=%b required 01", bus.port_gnt_o);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        set_port(1, 1'b1, 1'b0, 32'h20, 4'hF, '0);
        @(negedge clk);
        checks++;
        if (bus.port_gnt_o !== 2'b00 || bus.port_rvalid_o !== 2'b00) begin
            errors++;
            $display("FAIL squash_in_reset: gnt=%b rvalid=%b required 00 00", bus.port_gnt_o, bus.port_rvalid_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        model_access(0, 1'b0, 32'h10, 4'hF, '0);
        @(negedge clk);
        checks++;
        if (bus.port_rvalid_o !== 2'b00 || bus.port_gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL squash_after_reset: rvalid=%b gnt=%b required 00 01", bus.port_rvalid_o, bus.port_gnt_o);
        end
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
        drain("reset_squash");
    endtask

    task automatic test_monitor();
        logic [N-1:0] g, rv;
        checks++;
        if (mem_flag !== '0 || mem_result !== '0) begin
            errors++;
            $display("FAIL monitor_initial: flag=%h result=%h required 0 0", mem_flag, mem_result);
        end
        single_access(0, 1'b1, 32'h0FF0, 4'hF, 32'h0000_0001, g, rv);
        checks++;
        if (mem_flag !== tb_flag || mem_result !== tb_result) begin
            errors++;
            $display("FAIL monitor_flag: flag=%h result=%h required %h %h", mem_flag, mem_result, tb_flag, tb_result);
        end
        single_access(1, 1'b1, 32'h0FF4, 4'b0011, 32'h1234_BEEF, g, rv);
        checks++;
        if (mem_flag !== tb_flag || mem_result !== tb_result) begin
            errors++;
            $display("FAIL monitor_result: flag=%h result=%h required %h %h", mem_flag, mem_result, tb_flag, tb_result);
        end
        single_access(0, 1'b1, 32'h0FF0, 4'hF, 32'h7777_7777, g, rv);
        single_access(1, 1'b0, 32'h0FF0, 4'hF, '0, g, rv);
        checks++;
        if (mem_flag !== tb_flag || mem_result !== tb_result) begin
            errors++;
            $display("FAIL monitor_rewrite: flag=%h result=%h required %h %h", mem_flag, mem_result, tb_flag, tb_result);
        end
        drain("monitor");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.port_req_i   = '0;
        bus.port_we_i    = '0;
        bus.port_addr_i  = '0;
        bus.port_be_i    = '0;
        bus.port_wdata_i = '0;
        model_reset();
        test_reset();
        test_write_read();
        test_byte_enables();
        test_back_to_back();
        test_out_of_range();
        test_reset_squash();
        test_monitor();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
